ssd_scan_ctrl: RTL and testbench

- Owns the 8-digit seven-segment display and shares it between two requesters: src0 (doodle x/y position debug) and src1 (score).
- Each source gets a 1-deep pending buffer with a valid/ready handshake; the visible value updates only at frame boundaries, so digits never tear.
- Scans digits with a guard gap for anti-ghosting, supports leading-zero suppression, and selects the page as fixed, auto-rotating or blank.
- Replaces the free-running scan/decode logic in doodle_top.

---
 rtl/doodle_ssd_pkg.sv | 31 +++
 rtl/ssd_hex_decoder.sv | 32 +++
 rtl/ssd_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_ssd_pkg.sv
// Shared types and constants for the doodle seven-segment display controller.
// Font entries are active-low segment patterns ordered {a,b,c,d,e,f,g}.
package doodle_ssd_pkg;

  typedef enum logic [1:0] {
    MODE_SRC0  = 2'b00,
    MODE_SRC1  = 2'b01,
    MODE_AUTO  = 2'b10,
    MODE_BLANK = 2'b11
  } mode_e;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] FONT_0 = 7'b0000001;
  localparam logic [6:0] FONT_1 = 7'b1001111;
  localparam logic [6:0] FONT_2 = 7'b0010010;
  localparam logic [6:0] FONT_3 = 7'b0000110;
  localparam logic [6:0] FONT_4 = 7'b1001100;
  localparam logic [6:0] FONT_5 = 7'b0100100;
  localparam logic [6:0] FONT_6 = 7'b0100000;
  localparam logic [6:0] FONT_7 = 7'b0001111;
  localparam logic [6:0] FONT_8 = 7'b0000000;
  localparam logic [6:0] FONT_9 = 7'b0000100;
  localparam logic [6:0] FONT_A = 7'b0001000;
  localparam logic [6:0] FONT_B = 7'b1100000;
  localparam logic [6:0] FONT_C = 7'b0110001;
  localparam logic [6:0] FONT_D = 7'b1000010;
  localparam logic [6:0] FONT_E = 7'b0110000;
  localparam logic [6:0] FONT_F = 7'b0111000;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Output order is {a,b,c,d,e,f,g}.
module ssd_hex_decoder
  import doodle_ssd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = FONT_0;
    unique case (nib_i)
      4'h0: seg_o = FONT_0;
      4'h1: seg_o = FONT_1;
      4'h2: seg_o = FONT_2;
      4'h3: seg_o = FONT_3;
      4'h4: seg_o = FONT_4;
      4'h5: seg_o = FONT_5;
      4'h6: seg_o = FONT_6;
      4'h7: seg_o = FONT_7;
      4'h8: seg_o = FONT_8;
      4'h9: seg_o = FONT_9;
      4'hA: seg_o = FONT_A;
      4'hB: seg_o = FONT_B;
      4'hC: seg_o = FONT_C;
      4'hD: seg_o = FONT_D;
      4'hE: seg_o = FONT_E;
      4'hF: seg_o = FONT_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Eight-digit seven-segment scanner shared by two buffered sources.
// Visible values, mode and page only change at frame boundaries.
module ssd_scan_ctrl
  import doodle_ssd_pkg::*;
#(
  parameter int SCAN_DIV_W    = 17,
  parameter int GUARD_CYCLES  = 64,
  parameter int PAGE_FRAMES_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src0_data,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [31:0] src1_data,
  input  logic        src1_valid,
  output logic        src1_ready,
  input  logic [1:0]  mode,
  input  logic        lzs_en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        cur_page,
  output logic        frame_tick
);

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [SCAN_DIV_W-1:0] GUARD_L = SCAN_DIV_W'(GUARD_CYCLES);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_W-1:0]    presc_q;
  logic [DIG_W-1:0]         idx_q;
  logic [PAGE_FRAMES_W-1:0] frame_q, frame_d;
  mode_e                    mode_q;
  logic                     page_q, tick_q;
  logic [31:0]              pend0_q, pend1_q, disp0_q, disp1_q;
  logic                     full0_q, full1_q;
  logic [7:0]               an_q;
  logic [6:0]               seg_q, seg_w;
  logic                     dp_q;

  logic        term, boundary, guard, lz_blank;
  logic [31:0] sel_disp, upper;
  logic [3:0]  nib;

  assign term     = &presc_q;
  assign boundary = term && (idx_q == LAST_DIG);
  assign guard    = presc_q < GUARD_L;
  assign sel_disp = page_q ? disp1_q : disp0_q;
  assign nib      = sel_disp[{idx_q, 2'b00} +: 4];
  assign upper    = sel_disp >> {idx_q, 2'b00};
  assign lz_blank = lzs_en && (idx_q != '0) && (upper == 32'd0);
  assign frame_d  = frame_q + 1'b1;

  ssd_hex_decoder u_dec (
    .nib_i (nib),
    .seg_o (seg_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (term) idx_q <= idx_q + 1'b1;
    end
  end

  // A full buffer can't accept, so boundary drain and new transfer never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0_q <= '0;
      disp0_q <= '0;
      full0_q <= 1'b0;
    end else if (boundary && full0_q) begin
      disp0_q <= pend0_q;
      full0_q <= 1'b0;
    end else if (src0_valid && !full0_q) begin
      pend0_q <= src0_data;
      full0_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend1_q <= '0;
      disp1_q <= '0;
      full1_q <= 1'b0;
    end else if (boundary && full1_q) begin
      disp1_q <= pend1_q;
      full1_q <= 1'b0;
    end else if (src1_valid && !full1_q) begin
      pend1_q <= src1_data;
      full1_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_SRC0;
      page_q  <= 1'b0;
      frame_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= boundary;
      if (boundary) begin
        mode_q  <= mode_e'(mode);
        frame_q <= '0;
        unique case (mode_e'(mode))
          MODE_SRC0: page_q <= 1'b0;
          MODE_SRC1: page_q <= 1'b1;
          MODE_AUTO: begin
            frame_q <= frame_d;
            if (frame_d == '0) page_q <= ~page_q;
          end
          MODE_BLANK: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_w;
      dp_q  <= ~dp_mask[idx_q];
      if (mode_q == MODE_BLANK || guard || lz_blank) an_q <= '1;
      else an_q <= ~(8'd1 << idx_q);
    end
  end

  assign src0_ready = ~full0_q;
  assign src1_ready = ~full1_q;
  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign cur_page   = page_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed plus random bench for ssd_scan_ctrl against a cycle-count model.
// Small scan parameters keep frames at 128 clocks.
module tb_ssd_scan_ctrl;

  localparam int SDW   = 4;
  localparam int GC    = 2;
  localparam int PFW   = 1;
  localparam int SLOT  = 1 << SDW;
  localparam int FRAME = SLOT * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src0_data = '0, src1_data = '0;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic        src0_ready, src1_ready;
  logic [1:0]  mode = 2'b00;
  logic        lzs_en = 1'b0;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n, cur_page, frame_tick;

  int passed = 0, failed = 0, total = 0;

  logic [6:0] font [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          t;
  logic [31:0] m_pend [2];
  logic [31:0] m_disp [2];
  logic        m_full [2];
  logic [1:0]  m_mode;
  logic        m_page, m_tick;
  int          m_frame;
  logic        last_x0;

  ssd_scan_ctrl #(
    .SCAN_DIV_W    (SDW),
    .GUARD_CYCLES  (GC),
    .PAGE_FRAMES_W (PFW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0_data  (src0_data),
    .src0_valid (src0_valid),
    .src0_ready (src0_ready),
    .src1_data  (src1_data),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .mode       (mode),
    .lzs_en     (lzs_en),
    .dp_mask    (dp_mask),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .cur_page   (cur_page),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s t=%0d got %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic model_clear();
    t = 0;
    m_pend = '{32'd0, 32'd0};
    m_disp = '{32'd0, 32'd0};
    m_full = '{1'b0, 1'b0};
    m_mode = 2'b00;
    m_page = 1'b0;
    m_tick = 1'b0;
    m_frame = 0;
  endtask

  task automatic step();
    int p, i;
    logic bnd, x0, x1, e_dp;
    logic [31:0] v, d0, d1;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic [1:0] md;
    p   = t % SLOT;
    i   = (t / SLOT) % 8;
    bnd = (t % FRAME) == FRAME - 1;
    v   = m_page ? m_disp[1] : m_disp[0];
    e_an  = 8'hFF;
    e_seg = font[4'(v >> (4 * i))];
    e_dp  = ~dp_mask[i];
    if (m_mode != 2'b11 && p >= GC &&
        !(lzs_en && i != 0 && (v >> (4 * i)) == 32'd0))
      e_an = ~(8'd1 << i);
    x0 = src0_valid && !m_full[0];
    x1 = src1_valid && !m_full[1];
    d0 = src0_data;
    d1 = src1_data;
    md = mode;
    @(posedge clk);
    if (bnd && m_full[0]) begin m_disp[0] = m_pend[0]; m_full[0] = 1'b0; end
    else if (x0) begin m_pend[0] = d0; m_full[0] = 1'b1; end
    if (bnd && m_full[1]) begin m_disp[1] = m_pend[1]; m_full[1] = 1'b0; end
    else if (x1) begin m_pend[1] = d1; m_full[1] = 1'b1; end
    if (bnd) begin
      m_mode = md;
      if (md == 2'b00) m_page = 1'b0;
      if (md == 2'b01) m_page = 1'b1;
      if (md == 2'b10) begin
        m_frame = (m_frame + 1) % (1 << PFW);
        if (m_frame == 0) m_page = ~m_page;
      end else m_frame = 0;
    end
    m_tick  = bnd;
    last_x0 = x0;
    t++;
    #1;
    chk("an_n", 32'(an_n), 32'(e_an));
    if (e_an != 8'hFF) begin
      chk("seg_n", 32'(seg_n), 32'(e_seg));
      chk("dp_n", 32'(dp_n), 32'(e_dp));
    end
    chk("src0_ready", 32'(src0_ready), 32'(!m_full[0]));
    chk("src1_ready", 32'(src1_ready), 32'(!m_full[1]));
    chk("cur_page", 32'(cur_page), 32'(m_page));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_to(input int pos);
    while (t % FRAME != pos) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an_n", 32'(an_n), 32'hFF);
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_dp_n", 32'(dp_n), 32'h1);
    chk("rst_src0_ready", 32'(src0_ready), 32'h1);
    chk("rst_src1_ready", 32'(src1_ready), 32'h1);
    chk("rst_cur_page", 32'(cur_page), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic send0(input logic [31:0] w);
    src0_data  = w;
    src0_valid = 1'b1;
    step();
    src0_valid = 1'b0;
    src0_data  = $urandom;
  endtask

  function automatic logic [31:0] rnd_word();
    int k;
    k = $urandom_range(0, 8);
    return (k == 8) ? 32'd0 : (32'($urandom) >> (4 * k));
  endfunction

  initial begin
    logic [31:0] w2;
    int n;
    model_clear();
    do_reset();
    run(2 * FRAME);

    run_to(60);
    send0(32'h1234ABCD);
    run(2 * FRAME);

    send0($urandom);
    w2 = $urandom;
    src0_data  = w2;
    src0_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_x0 && n < 3 * FRAME);
    chk("backpressure_accept", 32'(last_x0), 32'h1);
    src0_valid = 1'b0;
    run(2 * FRAME);

    src0_data  = 32'h0;
    src1_data  = 32'hFFFFFFFF;
    src0_valid = 1'b1;
    src1_valid = 1'b1;
    step();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    mode = 2'b10;
    run(6 * FRAME);
    mode = 2'b11;
    run(2 * FRAME);
    mode = 2'b00;

    lzs_en = 1'b1;
    send0(32'h00000500);
    run(2 * FRAME);
    send0(32'h0);
    run(2 * FRAME);
    lzs_en = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        src0_valid = 1'($urandom_range(0, 1));
        src0_data  = rnd_word();
      end
      if ($urandom_range(0, 3) == 0) begin
        src1_valid = 1'($urandom_range(0, 1));
        src1_data  = rnd_word();
      end
      if ($urandom_range(0, 255) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 255) == 0) lzs_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) dp_mask = 8'($urandom);
      step();
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    mode = 2'b00;
    run(2 * FRAME);

    run_to(50);
    send0($urandom | 32'h1);
    run_to(4 * SLOT + 5);
    do_reset();
    run(FRAME + SLOT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
